// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and constants for the 1x3 router packet
//                sequencer: FSM state encoding and header address codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Packet-sequencing states (binary encoded, 3 bits).
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    // Header address field codes; ADDR_INV selects no output port.
    localparam logic [1:0] ADDR_0   = 2'd0;
    localparam logic [1:0] ADDR_1   = 2'd1;
    localparam logic [1:0] ADDR_2   = 2'd2;
    localparam logic [1:0] ADDR_INV = 2'd3;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_fsm_if
//  Description : Control bundle between the router input/sync/register
//                datapath and the packet-sequencing FSM.
//  Revision    : 1.0 - initial release
//
//  Signals:
//    pkt_valid, datain[1:0], parity_done, low_pkt_valid, fifo_full,
//    fifo_empty_0..2, soft_reset_0..2              : datapath -> FSM
//    detect_add, lfd_state, ld_state, laf_state, full_state,
//    write_enb_reg, rst_int_reg, busy               : FSM -> datapath
//  Modports:
//    master : datapath side (drives status, receives strobes)
//    slave  : FSM side (receives status, drives strobes)
// ============================================================================
interface router_fsm_if;

    logic       pkt_valid;
    logic [1:0] datain;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;

    modport master (
        output pkt_valid, datain, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, datain, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

endinterface : router_fsm_if
`default_nettype wire

// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : router_fsm
//  Description : Packet-sequencing controller for the 1x3 router. Walks each
//                packet through header -> payload -> parity -> check, stalls
//                on a full FIFO and waits for a busy destination to drain.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk   : system clock, rising edge
//    reset : asynchronous active-high reset, forces DECODE_ADDRESS
//    bus   : router_fsm_if.slave control bundle (status in, strobes out)
// ============================================================================
module router_fsm
    import router_pkg::*;
(
    input  wire          clk,
    input  wire          reset,
    router_fsm_if.slave  bus
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_addr;

    logic       w_addr_load;
    logic       w_hdr_empty;    // empty flag of the port named by the header
    logic       w_sel_empty;    // empty flag of the latched port
    logic       w_sel_soft;     // soft reset of the latched port

    assign w_addr_load = (r_state == DECODE_ADDRESS) && bus.pkt_valid &&
                         (bus.datain != ADDR_INV);

    always_comb begin
        w_hdr_empty = 1'b0;
        case (bus.datain)
            ADDR_0:  w_hdr_empty = bus.fifo_empty_0;
            ADDR_1:  w_hdr_empty = bus.fifo_empty_1;
            ADDR_2:  w_hdr_empty = bus.fifo_empty_2;
            default: w_hdr_empty = 1'b0;
        endcase
    end

    always_comb begin
        w_sel_empty = 1'b0;
        w_sel_soft  = 1'b0;
        case (r_addr)
            ADDR_0: begin
                w_sel_empty = bus.fifo_empty_0;
                w_sel_soft  = bus.soft_reset_0;
            end
            ADDR_1: begin
                w_sel_empty = bus.fifo_empty_1;
                w_sel_soft  = bus.soft_reset_1;
            end
            ADDR_2: begin
                w_sel_empty = bus.fifo_empty_2;
                w_sel_soft  = bus.soft_reset_2;
            end
            default: begin
                w_sel_empty = 1'b0;
                w_sel_soft  = 1'b0;
            end
        endcase
    end

    // State register and address latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= ADDR_0;
        end else begin
            r_state <= w_next_state;
            if (w_addr_load) begin
                r_addr <= bus.datain;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (r_state != DECODE_ADDRESS && w_sel_soft) begin
            // Timeout on the active port abandons the packet.
            w_next_state = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (w_addr_load) begin
                        w_next_state = w_hdr_empty ? LOAD_FIRST_DATA
                                                   : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
                LOAD_DATA: begin
                    // Full takes priority over the end-of-packet indication.
                    if (bus.fifo_full)       w_next_state = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) w_next_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!bus.fifo_full) w_next_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        w_next_state = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) w_next_state = LOAD_PARITY;
                    else                        w_next_state = LOAD_DATA;
                end
                LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    w_next_state = bus.fifo_full ? FIFO_FULL_STATE
                                                 : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (w_sel_empty) w_next_state = LOAD_FIRST_DATA;
                end
                default: w_next_state = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        bus.detect_add    = (r_state == DECODE_ADDRESS);
        bus.lfd_state     = (r_state == LOAD_FIRST_DATA);
        bus.ld_state      = (r_state == LOAD_DATA);
        bus.full_state    = (r_state == FIFO_FULL_STATE);
        bus.laf_state     = (r_state == LOAD_AFTER_FULL);
        bus.rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
        bus.write_enb_reg = (r_state == LOAD_DATA) ||
                            (r_state == LOAD_PARITY) ||
                            (r_state == LOAD_AFTER_FULL);
        bus.busy          = (r_state != DECODE_ADDRESS) &&
                            (r_state != LOAD_DATA);
    end

endmodule : router_fsm
`default_nettype wire

// File: tb/tb_router_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_fsm
//  Description : Self-checking bench for router_fsm. Each driven cycle pushes
//                the expected output vector for the following cycle into a
//                scoreboard queue; a monitor pops and compares after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fsm;

    // Output vector: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] C_DA   = 8'b1000_0000;
    localparam logic [7:0] C_LFD  = 8'b0100_0001;
    localparam logic [7:0] C_LD   = 8'b0010_0100;
    localparam logic [7:0] C_LAF  = 8'b0001_0101;
    localparam logic [7:0] C_FULL = 8'b0000_1001;
    localparam logic [7:0] C_LP   = 8'b0000_0101;
    localparam logic [7:0] C_CPE  = 8'b0000_0011;
    localparam logic [7:0] C_WTE  = 8'b0000_0001;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    router_fsm_if bus_if ();

    router_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    wire [7:0] w_outs = {bus_if.detect_add, bus_if.lfd_state, bus_if.ld_state,
                         bus_if.laf_state, bus_if.full_state,
                         bus_if.write_enb_reg, bus_if.rst_int_reg, bus_if.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: queue what the outputs must be after this edge.
    task automatic step(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: sample 1 time unit after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.tag, w_outs, e.exp);
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset                = 1'b1;
        bus_if.pkt_valid     = 1'b0;
        bus_if.datain        = 2'd0;
        bus_if.parity_done   = 1'b0;
        bus_if.low_pkt_valid = 1'b0;
        bus_if.fifo_full     = 1'b0;
        bus_if.fifo_empty_0  = 1'b1;
        bus_if.fifo_empty_1  = 1'b1;
        bus_if.fifo_empty_2  = 1'b1;
        bus_if.soft_reset_0  = 1'b0;
        bus_if.soft_reset_1  = 1'b0;
        bus_if.soft_reset_2  = 1'b0;

        // Reset state
        #1;
        check("reset_outs", w_outs, C_DA);
        check("reset_addr", {6'd0, dut.r_addr}, 8'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        step("idle", C_DA);

        // Packet to port 0, normal end of packet
        bus_if.pkt_valid = 1'b1; bus_if.datain = 2'd0;
        step("p0_lfd", C_LFD);
        step("p0_ld", C_LD);
        step("p0_ld_hold", C_LD);
        bus_if.pkt_valid = 1'b0;
        step("p0_lp", C_LP);
        step("p0_cpe", C_CPE);
        step("p0_da", C_DA);

        // Port 1 busy: wait until it drains, then stall on full
        bus_if.pkt_valid = 1'b1; bus_if.datain = 2'd1; bus_if.fifo_empty_1 = 1'b0;
        step("p1_wte", C_WTE);
        bus_if.pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) step("p1_wte_hold", C_WTE);
        bus_if.fifo_empty_1 = 1'b1;
        step("p1_lfd", C_LFD);
        bus_if.pkt_valid = 1'b1;
        step("p1_ld", C_LD);
        bus_if.fifo_full = 1'b1;
        step("p1_full", C_FULL);
        step("p1_full_hold", C_FULL);
        bus_if.fifo_full = 1'b0; bus_if.low_pkt_valid = 1'b1;
        step("p1_laf", C_LAF);
        step("p1_lp", C_LP);
        bus_if.low_pkt_valid = 1'b0; bus_if.pkt_valid = 1'b0;
        step("p1_cpe", C_CPE);
        step("p1_da", C_DA);

        // Full and end-of-packet together; full wins. Then parity path
        // re-entering full from CHECK_PARITY_ERROR and exit via parity_done.
        bus_if.pkt_valid = 1'b1; bus_if.datain = 2'd0;
        step("p0b_lfd", C_LFD);
        step("p0b_ld", C_LD);
        bus_if.pkt_valid = 1'b0; bus_if.fifo_full = 1'b1;
        step("p0b_full_wins", C_FULL);
        bus_if.fifo_full = 1'b0;
        step("p0b_laf", C_LAF);
        step("p0b_laf_to_ld", C_LD);
        step("p0b_lp", C_LP);
        bus_if.fifo_full = 1'b1;
        step("p0b_cpe", C_CPE);
        step("p0b_cpe_full", C_FULL);
        bus_if.fifo_full = 1'b0; bus_if.parity_done = 1'b1;
        step("p0b_laf2", C_LAF);
        step("p0b_parity_done", C_DA);
        bus_if.parity_done = 1'b0;

        // Packet to port 2: foreign soft reset ignored, own soft reset aborts
        bus_if.pkt_valid = 1'b1; bus_if.datain = 2'd2;
        step("p2_lfd", C_LFD);
        step("p2_ld", C_LD);
        bus_if.soft_reset_0 = 1'b1;
        step("p2_sr0_ignored", C_LD);
        bus_if.soft_reset_0 = 1'b0; bus_if.soft_reset_2 = 1'b1;
        bus_if.pkt_valid = 1'b0;
        step("p2_sr2_abort", C_DA);
        // Soft reset is not acted on in DECODE_ADDRESS, but is once past it
        bus_if.pkt_valid = 1'b1;
        step("p2_sr_in_da", C_LFD);
        bus_if.pkt_valid = 1'b0;
        step("p2_sr_in_lfd", C_DA);
        bus_if.soft_reset_2 = 1'b0;

        // Invalid address header is dropped; latched address kept
        bus_if.pkt_valid = 1'b1; bus_if.datain = 2'd3;
        step("inv_addr_stay", C_DA);
        step("inv_addr_stay2", C_DA);
        check("inv_addr_kept", {6'd0, dut.r_addr}, 8'd2);

        // Asynchronous reset while stalled on full
        bus_if.datain = 2'd0;
        step("r_lfd", C_LFD);
        step("r_ld", C_LD);
        bus_if.fifo_full = 1'b1;
        step("r_full", C_FULL);
        reset = 1'b1;
        #1;
        check("async_reset_outs", w_outs, C_DA);
        check("async_reset_addr", {6'd0, dut.r_addr}, 8'd0);
        step("reset_held", C_DA);
        reset = 1'b0; bus_if.fifo_full = 1'b0; bus_if.pkt_valid = 1'b0;
        step("post_reset_idle", C_DA);

        @(posedge clk); #2;
        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_router_fsm
`default_nettype wire

// File: doc/router_fsm.md
# router_fsm

Packet-sequencing controller for the 1x3 router. It watches the incoming header byte and the three output FIFOs' status, then drives the control strobes (`detect_add`, `write_enb_reg`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`, `busy`) consumed by the synchroniser and register blocks. It sits between the input port and the `sync`/register datapath and owns the header → payload → parity → check sequence for each packet.

## Interface
Parameters: none; widths fixed by the 1x3 topology.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces DECODE_ADDRESS.
- `pkt_valid` in 1: input byte valid; deassertion marks that the parity byte is next.
- `datain` in 2: address field of the header byte (`data_in[1:0]`).
- `parity_done` in 1: register block has loaded the parity byte.
- `low_pkt_valid` in 1: register block saw `pkt_valid` drop while the FIFO was full.
- `fifo_full` in 1: selected FIFO full (from `sync`).
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-FIFO timeout resets (from `sync`).
- `detect_add` out 1: header decode cycle.
- `lfd_state` out 1: loading header (first data) byte.
- `ld_state` out 1: loading payload.
- `laf_state` out 1: loading the byte held during full.
- `full_state` out 1: stalled on full FIFO.
- `write_enb_reg` out 1: write strobe to `sync`.
- `rst_int_reg` out 1: parity-check cycle; clears internal parity register.
- `busy` out 1: input must hold its byte.

## Operation
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Address register `addr[1:0]`: captured in DECODE_ADDRESS when `pkt_valid` is high and `datain` is not 3. It is held until the next capture. Reset value 0.
- Transitions:
  - DECODE_ADDRESS:
    - `pkt_valid` & `datain`=n (n in 0..2) & `fifo_empty_n` → LOAD_FIRST_DATA.
    - `pkt_valid` & `datain`=n & !`fifo_empty_n` → WAIT_TILL_EMPTY.
    - `datain`=3 or !`pkt_valid` → stay; the invalid address is dropped.
  - LOAD_FIRST_DATA → LOAD_DATA, unconditional.
  - LOAD_DATA:
    - `fifo_full` → FIFO_FULL_STATE.
    - else !`pkt_valid` → LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: !`fifo_full` → LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - `parity_done` → DECODE_ADDRESS.
    - else `low_pkt_valid` → LOAD_PARITY.
    - else → LOAD_DATA.
  - LOAD_PARITY → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: `fifo_full` → FIFO_FULL_STATE; else → DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: `fifo_empty_<addr>` → LOAD_FIRST_DATA; else stay.
- Soft reset: `soft_reset_<addr>` high in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next cycle. Soft resets of other ports are ignored.
- Priority: `reset` > soft reset > normal transitions.
- Outputs are Moore, decoded from the current state only:
  - `detect_add`: DECODE_ADDRESS.
  - `lfd_state`: LOAD_FIRST_DATA.
  - `ld_state`: LOAD_DATA.
  - `full_state`: FIFO_FULL_STATE.
  - `laf_state`: LOAD_AFTER_FULL.
  - `rst_int_reg`: CHECK_PARITY_ERROR.
  - `write_enb_reg`: LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
  - `busy`: every state except DECODE_ADDRESS and LOAD_DATA.

## Timing
- Reset values: state DECODE_ADDRESS, so `detect_add`=1 and all other outputs 0; `addr`=0.
- State register updates on the rising `clk` edge; outputs are valid the same cycle the state is entered and are glitch-free from registered state.
- Header to first write: header seen in DECODE_ADDRESS at cycle t; LOAD_FIRST_DATA at t+1; first `write_enb_reg` at t+2 (LOAD_DATA).
- `pkt_valid` drop in LOAD_DATA at t: LOAD_PARITY at t+1, CHECK_PARITY_ERROR at t+2, DECODE_ADDRESS at t+3.
- If `fifo_full` and `pkt_valid`=0 arrive in the same LOAD_DATA cycle, full wins and the FSM goes to FIFO_FULL_STATE.
- `reset` asserted mid-packet returns to DECODE_ADDRESS asynchronously; no further writes are issued.

## Structure
- `router_pkg`:
  - 3-bit state enum; one-hot encoding is not required.
  - Address constants `ADDR_0`=0, `ADDR_1`=1, `ADDR_2`=2, `ADDR_INV`=3.
- Single module with no sub-modules: state register, next-state logic, address latch, output decode.

## Test plan
- Reset, then `pkt_valid`=1, `datain`=0, `fifo_empty_0`=1 → `detect_add` 1→0, `lfd_state`=1 next cycle, then `ld_state`=1 and `write_enb_reg`=1, `busy`=0.
- `datain`=1, `fifo_empty_1`=0 for 5 cycles → WAIT_TILL_EMPTY with `busy`=1 and `write_enb_reg`=0; raise `fifo_empty_1` → LOAD_FIRST_DATA next cycle.
- In LOAD_DATA raise `fifo_full` → `full_state`=1, `busy`=1 until `fifo_full`=0; then `laf_state`=1 and `write_enb_reg`=1. With `low_pkt_valid`=1 → LOAD_PARITY, then `rst_int_reg`=1.
- `pkt_valid` drops in LOAD_DATA → LOAD_PARITY (`write_enb_reg`=1, `busy`=1), CHECK_PARITY_ERROR (`rst_int_reg`=1), DECODE_ADDRESS.
- Packet to port 2 in LOAD_DATA: `soft_reset_0` pulse → no effect; `soft_reset_2` pulse → `detect_add`=1 next cycle.
- `datain`=3 with `pkt_valid`=1 → stays in DECODE_ADDRESS, `addr` unchanged. Assert `reset` during FIFO_FULL_STATE → `detect_add`=1 immediately, without waiting for a clock edge.
